// File: rtl/bb_pkg.sv
// Shared constants, output-register state encoding and the sample sign-extension
// helper for the baseband decimator.
package bb_pkg;

    localparam int unsigned DECIM = 4;
    localparam int unsigned IN_W  = 5;
    localparam int unsigned OUT_W = 7;
    localparam int unsigned PH_W  = $clog2(DECIM);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
        return OUT_W'(x);
    endfunction

endpackage

// File: rtl/bb_decim_if.sv
// Strobed IQ sample input bus and the valid/ready decimated output bus.
interface bb_in_if;
    import bb_pkg::*;

    logic                    demod_rdy;
    logic signed [IN_W-1:0]  I_BB;
    logic signed [IN_W-1:0]  Q_BB;

    modport master (output demod_rdy, I_BB, Q_BB);
    modport slave  (input  demod_rdy, I_BB, Q_BB);
endinterface

interface bb_dec_if;
    import bb_pkg::*;

    logic signed [OUT_W-1:0] I_DEC;
    logic signed [OUT_W-1:0] Q_DEC;
    logic                    dec_valid;
    logic                    dec_ready;

    modport master (output I_DEC, Q_DEC, dec_valid, input  dec_ready);
    modport slave  (input  I_DEC, Q_DEC, dec_valid, output dec_ready);
endinterface

// File: rtl/bb_acc.sv
// Single-channel integrate-and-dump accumulator; sum_c is the dump value
// (accumulator plus the current sign-extended sample).
module bb_acc
    import bb_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    strobe,
    input  logic                    dump,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [OUT_W-1:0] sum_c
);

    logic signed [OUT_W-1:0] acc;

    assign sum_c = acc + sext(sample);

    // Accumulate strobed samples; restart from zero after a dump or clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (strobe) begin
            if (dump) begin
                acc <= '0;
            end else begin
                acc <= sum_c;
            end
        end
    end

endmodule

// File: rtl/bb_decim.sv
// Decimate-by-4 integrate-and-dump for the IQ baseband stream, with a
// one-entry output register and sticky overflow on dropped results.
module bb_decim
    import bb_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    bb_in_if.slave          in_bus,
    bb_dec_if.master        dec_bus,
    output logic            ovf
);

    logic [PH_W-1:0]         phase;
    logic                    strobe_c;
    logic                    dump_c;
    logic signed [OUT_W-1:0] i_sum_c;
    logic signed [OUT_W-1:0] q_sum_c;
    out_state_t              state;
    logic signed [OUT_W-1:0] i_dec;
    logic signed [OUT_W-1:0] q_dec;
    logic                    dec_valid;

    // clear takes priority: a strobe coinciding with clear is discarded.
    assign strobe_c = in_bus.demod_rdy & ~clear;
    assign dump_c   = strobe_c & (phase == PH_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (strobe_c) begin
            phase <= dump_c ? '0 : phase + PH_W'(1);
        end
    end

    bb_acc u_acc_i (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .strobe (strobe_c),
        .dump   (dump_c),
        .sample (in_bus.I_BB),
        .sum_c  (i_sum_c)
    );

    bb_acc u_acc_q (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .strobe (strobe_c),
        .dump   (dump_c),
        .sample (in_bus.Q_BB),
        .sum_c  (q_sum_c)
    );

    // Output register FSM: a dump into a FULL register is kept only if the
    // held result is consumed in the same cycle, otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= EMPTY;
            i_dec     <= '0;
            q_dec     <= '0;
            dec_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (dump_c) begin
                        state     <= FULL;
                        i_dec     <= i_sum_c;
                        q_dec     <= q_sum_c;
                        dec_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (dump_c && dec_bus.dec_ready) begin
                        i_dec <= i_sum_c;
                        q_dec <= q_sum_c;
                    end else if (dump_c) begin
                        ovf <= 1'b1;
                    end else if (dec_bus.dec_ready) begin
                        state     <= EMPTY;
                        dec_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    dec_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dec_bus.I_DEC     = i_dec;
    assign dec_bus.Q_DEC     = q_dec;
    assign dec_bus.dec_valid = dec_valid;

endmodule

// File: tb/tb_bb_decim.sv
// Directed bench for bb_decim: hand-computed sums, gaps, backpressure,
// clear and reset scenarios.
module tb_bb_decim;

    logic clk;
    logic resetn;
    logic clear;
    logic ovf;
    int   total;
    int   bad;

    bb_in_if  in_bus ();
    bb_dec_if dec_bus ();

    bb_decim dut (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .in_bus  (in_bus.slave),
        .dec_bus (dec_bus.master),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; return 1ns after the rising edge.
    task automatic step(input logic rdy, input int i, input int q,
                        input logic clr, input logic drdy);
        @(negedge clk);
        in_bus.demod_rdy  = rdy;
        in_bus.I_BB       = 5'(i);
        in_bus.Q_BB       = 5'(q);
        clear             = clr;
        dec_bus.dec_ready = drdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic drdy);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, drdy);
    endtask

    function automatic int si(input logic [6:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        in_bus.demod_rdy  = 1'b0;
        in_bus.I_BB       = '0;
        in_bus.Q_BB       = '0;
        clear             = 1'b0;
        dec_bus.dec_ready = 1'b0;

        // Reset with strobes/clear/ready toggling (all ignored)
        step(1'b1, 5, 5, 1'b1, 1'b1);
        step(1'b1, 5, 5, 1'b0, 1'b0);
        chk("rst_i", si(dec_bus.I_DEC), 0);
        chk("rst_q", si(dec_bus.Q_DEC), 0);
        chk("rst_valid", int'(dec_bus.dec_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        resetn = 1'b1;

        // Basic sum
        for (int k = 0; k < 4; k++) step(1'b1, 3, -2, 1'b0, 1'b1);
        chk("basic_valid", int'(dec_bus.dec_valid), 1);
        chk("basic_i", si(dec_bus.I_DEC), 12);
        chk("basic_q", si(dec_bus.Q_DEC), -8);
        idle(1, 1'b1);
        chk("basic_valid_1cyc", int'(dec_bus.dec_valid), 0);

        // Extremes with gaps of 1, 3, 7 idle cycles
        step(1'b1, -16, 15, 1'b0, 1'b1);
        idle(1, 1'b1);
        step(1'b1, -16, 15, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, -16, 15, 1'b0, 1'b1);
        chk("gap_no_early", int'(dec_bus.dec_valid), 0);
        idle(7, 1'b1);
        step(1'b1, -16, 15, 1'b0, 1'b1);
        chk("ext_valid", int'(dec_bus.dec_valid), 1);
        chk("ext_i", si(dec_bus.I_DEC), -64);
        chk("ext_q", si(dec_bus.Q_DEC), 60);
        idle(1, 1'b1);
        chk("ext_valid_drop", int'(dec_bus.dec_valid), 0);

        // Backpressure: second result dropped, ovf sticky
        for (int k = 0; k < 4; k++) step(1'b1, 1, 0, 1'b0, 1'b0);
        chk("bp_first_i", si(dec_bus.I_DEC), 4);
        chk("bp_first_ovf", int'(ovf), 0);
        for (int k = 0; k < 3; k++) step(1'b1, 2, 0, 1'b0, 1'b0);
        step(1'b1, 2, 0, 1'b0, 1'b0);
        chk("bp_hold_i", si(dec_bus.I_DEC), 4);
        chk("bp_hold_valid", int'(dec_bus.dec_valid), 1);
        chk("bp_ovf", int'(ovf), 1);
        idle(1, 1'b1);
        chk("bp_drain_valid", int'(dec_bus.dec_valid), 0);
        chk("bp_ovf_sticky", int'(ovf), 1);
        idle(2, 1'b1);
        chk("bp_ovf_sticky2", int'(ovf), 1);

        // Reset clears ovf
        resetn = 1'b0;
        idle(1, 1'b0);
        resetn = 1'b1;
        chk("ovf_rst", int'(ovf), 0);

        // Ready coincident with the next dump in FULL: replace, no loss
        for (int k = 0; k < 4; k++) step(1'b1, 1, 1, 1'b0, 1'b0);
        chk("sim_first_i", si(dec_bus.I_DEC), 4);
        for (int k = 0; k < 3; k++) step(1'b1, 2, -1, 1'b0, 1'b0);
        step(1'b1, 2, -1, 1'b0, 1'b1);
        chk("sim_i", si(dec_bus.I_DEC), 8);
        chk("sim_q", si(dec_bus.Q_DEC), -4);
        chk("sim_valid", int'(dec_bus.dec_valid), 1);
        chk("sim_ovf", int'(ovf), 0);
        idle(1, 1'b1);
        chk("sim_drain", int'(dec_bus.dec_valid), 0);

        // Clear with 3rd strobe
        step(1'b1, 5, 0, 1'b0, 1'b1);
        step(1'b1, 5, 0, 1'b0, 1'b1);
        step(1'b1, 5, 0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 2, 0, 1'b0, 1'b1);
        chk("clr_no_early", int'(dec_bus.dec_valid), 0);
        step(1'b1, 2, 0, 1'b0, 1'b1);
        chk("clr_valid", int'(dec_bus.dec_valid), 1);
        chk("clr_i", si(dec_bus.I_DEC), 8);
        idle(1, 1'b1);

        // Clear on the 4th strobe: no dump
        for (int k = 0; k < 3; k++) step(1'b1, 1, 0, 1'b0, 1'b1);
        step(1'b1, 1, 0, 1'b1, 1'b1);
        chk("clr4_no_dump", int'(dec_bus.dec_valid), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 3, 0, 1'b0, 1'b0);
        chk("clr4_i", si(dec_bus.I_DEC), 12);
        chk("clr4_valid", int'(dec_bus.dec_valid), 1);

        // Reset mid-operation with FULL pending
        for (int k = 0; k < 3; k++) step(1'b1, 7, 7, 1'b0, 1'b0);
        resetn = 1'b0;
        step(1'b1, 7, 7, 1'b0, 1'b1);
        chk("mid_rst_i", si(dec_bus.I_DEC), 0);
        chk("mid_rst_q", si(dec_bus.Q_DEC), 0);
        chk("mid_rst_valid", int'(dec_bus.dec_valid), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1, -1, 1'b0, 1'b1);
        chk("mid_no_early", int'(dec_bus.dec_valid), 0);
        step(1'b1, 1, -1, 1'b0, 1'b1);
        chk("mid_i", si(dec_bus.I_DEC), 4);
        chk("mid_q", si(dec_bus.Q_DEC), -4);
        chk("mid_valid", int'(dec_bus.dec_valid), 1);
        idle(2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
